// File: rtl/key_pkg.sv
// Key codes, scan-code constants and the set-2 scan map shared by the
// PS/2 key decoder and the menu drawing stage.
package key_pkg;

  typedef enum logic [3:0] {
    KEY_NONE = 4'h0,
    KEY_1    = 4'h1,
    KEY_2    = 4'h2,
    KEY_3    = 4'h3,
    KEY_4    = 4'h4,
    KEY_ESC  = 4'hF
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2
  } ps2_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Set-2 make code to menu key; anything not listed is unmapped.
  function automatic key_t scan_to_key(input logic [7:0] code);
    case (code)
      8'h16:   scan_to_key = KEY_1;
      8'h1E:   scan_to_key = KEY_2;
      8'h26:   scan_to_key = KEY_3;
      8'h25:   scan_to_key = KEY_4;
      8'h76:   scan_to_key = KEY_ESC;
      default: scan_to_key = KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the asynchronous PS/2 clock and data pins into the local
// clock domain and flags the falling edge of the synchronized PS/2 clock.
// Both lines use identical chain depth so data stays aligned with the edge.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_s,
  output logic fall_en
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;

  // Synchronizer chains idle high, matching the released PS/2 bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign fall_en = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 keyboard decoder: receives 11-bit frames, validates start,
// odd parity and stop, follows E0/F0 prefixes, and holds the code of the
// currently pressed mapped key until it is released.
module ps2_key_decoder
  import key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 130000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned     TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic             data_s;
  logic             fall_en;
  ps2_state_t       state_q;
  logic [3:0]       bit_cnt_q;
  logic [TMO_W-1:0] tmo_q;
  logic [9:0]       shift_q;
  logic             brk_q;
  logic             ext_q;
  key_t             key_q;
  logic             key_valid_q;
  logic             frame_err_q;
  logic [7:0]       code;
  key_t             code_key;
  logic             frame_ok;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_s   (data_s),
    .fall_en  (fall_en)
  );

  // Frame payload: after ten shifts [7:0]=data, [8]=parity, [9]=stop.
  always_ff @(posedge clk) begin
    if (state_q == ST_RECEIVE && fall_en) begin
      shift_q <= {data_s, shift_q[9:1]};
    end
  end

  assign code     = shift_q[7:0];
  assign code_key = scan_to_key(code);
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);

  // Frame receiver, prefix tracking and registered key/pulse outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_q       <= KEY_NONE;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q     <= '0;
          bit_cnt_q <= '0;
          if (fall_en) begin
            if (!data_s) state_q     <= ST_RECEIVE;
            else         frame_err_q <= 1'b1;
          end
        end
        ST_RECEIVE: begin
          if (fall_en) begin
            tmo_q     <= '0;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_q <= ST_CHECK;
          end else if (tmo_q == TMO_LAST) begin
            // Stalled partial frame: drop it but keep pending prefixes.
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_CHECK: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
          tmo_q     <= '0;
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
          end else if (code == SC_EXT) begin
            ext_q <= 1'b1;
          end else if (code == SC_BREAK) begin
            brk_q <= 1'b1;
          end else if (ext_q) begin
            // Extended keys are not used by the menu.
            ext_q <= 1'b0;
            brk_q <= 1'b0;
          end else if (brk_q) begin
            // Only releasing the held key clears it; stale releases are ignored.
            brk_q <= 1'b0;
            if (code_key == key_q) key_q <= KEY_NONE;
          end else if (code_key != KEY_NONE && code_key != key_q) begin
            key_q       <= code_key;
            key_valid_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign frame_err = frame_err_q;

endmodule
